// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV immediate generator with valid/ready and illegal-opcode counter
module imm_gen_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_data,
    output logic [2:0]      imm_type,
    output logic            imm_illegal,
    output logic [15:0]     illegal_count
);

    logic            src_valid;
    logic [31:0]     src_instr;
    logic            b_valid;
    logic [XLEN-1:0] b_imm;
    logic [2:0]      b_type;
    logic            b_ill;
    logic            b_load;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_ill;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [15:0]     cnt_q;

    // Output slot accepts whenever it is empty or its content leaves this cycle.
    assign b_load = !b_valid || out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic        a_valid;
            logic [31:0] a_instr;
            logic        a_load;

            assign a_load   = !a_valid || b_load;
            assign in_ready = !reset && !flush && a_load;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_valid <= 1'b0;
                    a_instr <= '0;
                end else if (flush) begin
                    a_valid <= 1'b0;
                    a_instr <= '0;
                end else if (a_load) begin
                    a_valid <= in_valid;
                    if (in_valid) begin
                        a_instr <= instruction;
                    end
                end
            end

            assign src_valid = a_valid;
            assign src_instr = a_instr;
        end else begin : g_one
            assign in_ready  = !reset && !flush && b_load;
            assign src_valid = in_valid;
            assign src_instr = instruction;
        end
    endgenerate

    assign opcode   = src_instr[6:0];
    assign funct3   = src_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Sign extension always comes from bit 31 via signed size casts; shamt is zero-extended.
    always_comb begin
        dec_imm  = '0;
        dec_type = 3'd0;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_type = 3'd1;
                if (is_shift) begin
                    dec_imm = (XLEN == 64) ? XLEN'(src_instr[25:20]) : XLEN'(src_instr[24:20]);
                end else begin
                    dec_imm = XLEN'($signed(src_instr[31:20]));
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_type = 3'd1;
                dec_imm  = XLEN'($signed(src_instr[31:20]));
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_type = 3'd1;
                    if (is_shift) begin
                        dec_imm = XLEN'(src_instr[24:20]);
                    end else begin
                        dec_imm = XLEN'($signed(src_instr[31:20]));
                    end
                end else begin
                    dec_type = 3'd7;
                    dec_ill  = 1'b1;
                end
            end
            7'b0100011: begin
                dec_type = 3'd2;
                dec_imm  = XLEN'($signed({src_instr[31:25], src_instr[11:7]}));
            end
            7'b1100011: begin
                dec_type = 3'd3;
                dec_imm  = XLEN'($signed({src_instr[31], src_instr[7], src_instr[30:25],
                                          src_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_type = 3'd4;
                dec_imm  = XLEN'($signed({src_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_type = 3'd5;
                dec_imm  = XLEN'($signed({src_instr[31], src_instr[19:12], src_instr[20],
                                          src_instr[30:21], 1'b0}));
            end
            7'b0110011: begin
                dec_type = 3'd0;
            end
            7'b0111011: begin
                if (XLEN != 64) begin
                    dec_type = 3'd7;
                    dec_ill  = 1'b1;
                end
            end
            default: begin
                dec_type = 3'd7;
                dec_ill  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_valid <= 1'b0;
            b_imm   <= '0;
            b_type  <= 3'd0;
            b_ill   <= 1'b0;
        end else if (flush) begin
            b_valid <= 1'b0;
            b_imm   <= '0;
            b_type  <= 3'd0;
            b_ill   <= 1'b0;
        end else if (b_load) begin
            b_valid <= src_valid;
            if (src_valid) begin
                b_imm  <= dec_imm;
                b_type <= dec_type;
                b_ill  <= dec_ill;
            end
        end
    end

    // Counts delivered illegals, including a handshake that coincides with flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (b_valid && out_ready && b_ill && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_valid     = b_valid;
    assign imm_data      = b_imm;
    assign imm_type      = b_type;
    assign imm_illegal   = b_ill;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe in three XLEN/STAGES configurations
module tb_imm_gen_pipe;

    localparam int ND = 3;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [2:0]  t64;
        logic        i64;
        logic [31:0] imm32;
        logic [2:0]  t32;
        logic        i32;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_t [ND];
    logic        iv      [ND];
    logic        ordy    [ND];
    logic [31:0] ins     [ND];
    logic        rdy     [ND];
    logic        ov      [ND];
    logic [2:0]  typ     [ND];
    logic        ill     [ND];
    logic [15:0] cnt     [ND];
    logic [63:0] imm     [2];
    logic [31:0] imm32;

    logic [63:0] e_imm [ND];
    logic [2:0]  e_typ [ND];
    logic        e_ill [ND];

    sb_t         q [ND][$];
    int          stg [ND] = '{1, 2, 1};
    logic        stall_prev [ND];
    logic [67:0] held [ND];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        lat_on = 1'b0;
    vec_t        tv [19];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe #(.XLEN(64), .STAGES(1)) u_d0 (
        .clk(clk), .reset(reset), .flush(flush_t[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .instruction(ins[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .imm_data(imm[0]),
        .imm_type(typ[0]), .imm_illegal(ill[0]), .illegal_count(cnt[0]));

    imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush_t[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .instruction(ins[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .imm_data(imm[1]),
        .imm_type(typ[1]), .imm_illegal(ill[1]), .illegal_count(cnt[1]));

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush_t[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
        .instruction(ins[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .imm_data(imm32),
        .imm_type(typ[2]), .imm_illegal(ill[2]), .illegal_count(cnt[2]));

    function automatic logic [63:0] imm_of(input int i);
        if (i == 2) return {32'b0, imm32};
        return imm[i];
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop on output handshake, check in_ready and hold.
    always @(negedge clk) begin
        sb_t e;
        sb_t n;
        for (int i = 0; i < ND; i++) begin
            if (reset) begin
                q[i].delete();
                stall_prev[i] = 1'b0;
            end else begin
                chk($sformatf("in_ready[%0d]", i), 72'(rdy[i]),
                    72'(!flush_t[i] && ((q[i].size() < stg[i]) || ordy[i])));
                if (stall_prev[i]) begin
                    chk($sformatf("hold[%0d]", i), {ov[i], imm_of(i), typ[i], ill[i]}, {1'b1, held[i]});
                end
                if (ov[i] && ordy[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("spurious_out[%0d]", i), 72'(q[i].size()), 72'd1);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("result[%0d]", i), {imm_of(i), typ[i], ill[i]}, {e.imm, e.typ, e.ill});
                        if (lat_on) begin
                            chk($sformatf("latency[%0d]", i), 72'(cyc - e.cyc), 72'(stg[i]));
                        end
                    end
                end
                stall_prev[i] = ov[i] && !ordy[i] && !flush_t[i];
                held[i] = {imm_of(i), typ[i], ill[i]};
                if (flush_t[i]) q[i].delete();
                if (iv[i] && rdy[i]) begin
                    n.imm = e_imm[i];
                    n.typ = e_typ[i];
                    n.ill = e_ill[i];
                    n.cyc = cyc;
                    q[i].push_back(n);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < ND; i++) begin
            iv[i] = 1'b0;
            flush_t[i] = 1'b0;
            ordy[i] = 1'b1;
        end
    endtask

    task automatic set_in(input int i, input logic [31:0] w, input logic [63:0] im,
                          input logic [2:0] t, input logic il);
        iv[i] = 1'b1;
        ins[i] = w;
        e_imm[i] = im;
        e_typ[i] = t;
        e_ill[i] = il;
    endtask

    task automatic set_vec(input int i, input int k);
        if (i == 2) set_in(i, tv[k].instr, {32'b0, tv[k].imm32}, tv[k].t32, tv[k].i32);
        else        set_in(i, tv[k].instr, tv[k].imm64, tv[k].t64, tv[k].i64);
    endtask

    initial begin
        int ill64;
        int ill32;
        int w;
        int pat [6];
        logic acc;
        logic [15:0] c_before;

        tv[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
        tv[1]  = '{32'h0020A423, 64'h8,                3'd2, 1'b0, 32'h8,        3'd2, 1'b0};
        tv[2]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0};
        tv[3]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
        tv[4]  = '{32'h001000EF, 64'h800,              3'd5, 1'b0, 32'h800,      3'd5, 1'b0};
        tv[5]  = '{32'h03F09093, 64'h3F,               3'd1, 1'b0, 32'h1F,       3'd1, 1'b0};
        tv[6]  = '{32'h0000001B, 64'h0,                3'd1, 1'b0, 32'h0,        3'd7, 1'b1};
        tv[7]  = '{32'h00000000, 64'h0,                3'd7, 1'b1, 32'h0,        3'd7, 1'b1};
        tv[8]  = '{32'h00A00033, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
        tv[9]  = '{32'h0000003B, 64'h0,                3'd0, 1'b0, 32'h0,        3'd7, 1'b1};
        tv[10] = '{32'h4210D09B, 64'h1,                3'd1, 1'b0, 32'h0,        3'd7, 1'b1};
        tv[11] = '{32'h80000067, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0, 32'hFFFFF800, 3'd1, 1'b0};
        tv[12] = '{32'hC3F0D013, 64'h3F,               3'd1, 1'b0, 32'h1F,       3'd1, 1'b0};
        tv[13] = '{32'h12345017, 64'h12345000,         3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0};
        tv[14] = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0};
        tv[15] = '{32'h00000073, 64'h0,                3'd1, 1'b0, 32'h0,        3'd1, 1'b0};
        tv[16] = '{32'h0000007F, 64'h0,                3'd7, 1'b1, 32'h0,        3'd7, 1'b1};
        tv[17] = '{32'hFF9FF06F, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0, 32'hFFFFFFF8, 3'd5, 1'b0};
        tv[18] = '{32'h00208463, 64'h8,                3'd3, 1'b0, 32'h8,        3'd3, 1'b0};
        pat = '{1, 0, 0, 1, 1, 0};

        reset = 1'b1;
        for (int i = 0; i < ND; i++) begin
            ins[i] = '0;
            e_imm[i] = '0;
            e_typ[i] = '0;
            e_ill[i] = 1'b0;
            stall_prev[i] = 1'b0;
        end
        idle_all();
        #2;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset_state[%0d]", i), {ov[i], imm_of(i), typ[i], ill[i], cnt[i], rdy[i]}, 72'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Three illegal handshakes per configuration.
        lat_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ND; i++) set_in(i, 32'h0, 64'h0, 3'd7, 1'b1);
            tick();
        end
        idle_all();
        repeat (4) tick();
        for (int i = 0; i < ND; i++) chk($sformatf("ill_count3[%0d]", i), 72'(cnt[i]), 72'd3);

        // Back-to-back decode table through every configuration.
        ill64 = 0;
        ill32 = 0;
        for (int k = 0; k < 19; k++) begin
            for (int i = 0; i < ND; i++) set_vec(i, k);
            ill64 += int'(tv[k].i64);
            ill32 += int'(tv[k].i32);
            tick();
        end
        idle_all();
        repeat (4) tick();
        chk("ill_count_tbl[0]", 72'(cnt[0]), 72'(3 + ill64));
        chk("ill_count_tbl[1]", 72'(cnt[1]), 72'(3 + ill64));
        chk("ill_count_tbl[2]", 72'(cnt[2]), 72'(3 + ill32));

        // Two-stage backpressure with a toggling consumer.
        lat_on = 1'b0;
        w = 0;
        for (int c = 0; c < 60; c++) begin
            ordy[1] = pat[c % 6][0];
            if (w < 4) set_vec(1, w);
            else iv[1] = 1'b0;
            @(negedge clk);
            acc = iv[1] && rdy[1];
            @(posedge clk);
            #1;
            if (acc) w++;
            if (w == 4 && q[1].size() == 0) break;
        end
        idle_all();
        chk("bp_drain", {32'(w), 32'(q[1].size())}, {32'd4, 32'd0});

        // Flush with both stages full and a new word offered.
        ordy[1] = 1'b0;
        set_in(1, 32'h0, 64'h0, 3'd7, 1'b1);
        tick();
        tick();
        set_in(1, 32'h00000013, 64'h0, 3'd1, 1'b0);
        flush_t[1] = 1'b1;
        @(negedge clk);
        c_before = cnt[1];
        @(posedge clk);
        #1;
        chk("flush_out", {ov[1], imm_of(1), typ[1], ill[1]}, 72'd0);
        chk("flush_count", 72'(cnt[1]), 72'(c_before));
        idle_all();
        repeat (4) tick();

        // Flush coinciding with an illegal output handshake still counts it.
        ordy[1] = 1'b0;
        set_in(1, 32'h0, 64'h0, 3'd7, 1'b1);
        tick();
        iv[1] = 1'b0;
        tick();
        flush_t[1] = 1'b1;
        ordy[1] = 1'b1;
        @(negedge clk);
        c_before = cnt[1];
        @(posedge clk);
        #1;
        chk("flush_hs_count", {ov[1], cnt[1]}, {1'b0, c_before + 16'd1});
        idle_all();
        repeat (2) tick();

        // Asynchronous reset mid-stream, then first word latency.
        lat_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ND; i++) set_vec(i, k);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset_mid[%0d]", i), {ov[i], imm_of(i), typ[i], ill[i], cnt[i], rdy[i]}, 72'd0);
        end
        idle_all();
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < ND; i++) set_vec(i, 17);
        tick();
        idle_all();
        repeat (4) tick();

        // Saturation of the illegal counter.
        set_in(0, 32'h0, 64'h0, 3'd7, 1'b1);
        repeat (65540) tick();
        idle_all();
        repeat (3) tick();
        chk("ill_saturate", 72'(cnt[0]), 72'hFFFF);

        for (int i = 0; i < ND; i++) chk($sformatf("sb_empty[%0d]", i), 72'(q[i].size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
